// File: rtl/conv1d_layer_serialiser_if.sv
// Bus between the conv1d layer's parallel output, the serialiser and the next layer.
// The slave modport is the serialiser's view; the master modport is the environment's.
interface conv1d_layer_serialiser_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_FILTERS = 32
);
  localparam int CHANNEL_WIDTH = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

  logic                     serialiser_ready_in;
  logic [NUM_FILTERS-1:0]   serialiser_valid_in;
  logic [DATA_WIDTH-1:0]    serialiser_data_in [0:NUM_FILTERS-1];
  logic                     serialiser_ready_out;
  logic                     serialiser_valid_out;
  logic [DATA_WIDTH-1:0]    serialiser_data_out;
  logic [CHANNEL_WIDTH-1:0] serialiser_channel_out;
  logic                     serialiser_last_out;
  logic                     serialiser_valid_mismatch;

  modport master (
    input  serialiser_ready_in,
    output serialiser_valid_in,
    output serialiser_data_in,
    output serialiser_ready_out,
    input  serialiser_valid_out,
    input  serialiser_data_out,
    input  serialiser_channel_out,
    input  serialiser_last_out,
    input  serialiser_valid_mismatch
  );

  modport slave (
    output serialiser_ready_in,
    input  serialiser_valid_in,
    input  serialiser_data_in,
    input  serialiser_ready_out,
    output serialiser_valid_out,
    output serialiser_data_out,
    output serialiser_channel_out,
    output serialiser_last_out,
    output serialiser_valid_mismatch
  );
endinterface

// File: rtl/conv1d_layer_serialiser.sv
// Captures one NUM_FILTERS-wide vector of filter results and replays it as a
// single-lane ready/valid stream, channel 0 first, with optional ReLU on the way out.
module conv1d_layer_serialiser #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_FILTERS = 32,
  parameter int APPLY_RELU  = 0
) (
  input logic                      clk,
  input logic                      rst,
  conv1d_layer_serialiser_if.slave bus
);

  localparam int CHANNEL_WIDTH = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam logic [CHANNEL_WIDTH-1:0] LAST_CH = CHANNEL_WIDTH'(NUM_FILTERS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [CHANNEL_WIDTH-1:0] cnt_q, cnt_d;
  logic                     valid_q, valid_d;
  logic                     mismatch_q, mismatch_d;
  logic [DATA_WIDTH-1:0]    buf_q [0:NUM_FILTERS-1];

  logic                     last_s;
  logic                     handshake_s;
  logic                     ready_in_s;
  logic                     accept_s;
  logic                     partial_s;
  logic [DATA_WIDTH-1:0]    sample_s;
  logic [DATA_WIDTH-1:0]    data_out_s;

  assign last_s      = (cnt_q == LAST_CH);
  assign handshake_s = valid_q & bus.serialiser_ready_out;
  // The final beat leaving frees the buffer, so a new vector may land on the same edge.
  assign ready_in_s  = (state_q == IDLE) | (valid_q & last_s & bus.serialiser_ready_out);
  assign accept_s    = ready_in_s & (&bus.serialiser_valid_in);
  assign partial_s   = ready_in_s & (|bus.serialiser_valid_in) & ~(&bus.serialiser_valid_in);
  assign sample_s    = buf_q[cnt_q];

  always_comb begin
    if ((APPLY_RELU != 0) && sample_s[DATA_WIDTH-1]) begin
      data_out_s = '0;
    end else begin
      data_out_s = sample_s;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    mismatch_d = mismatch_q | partial_s;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = SEND;
          cnt_d   = '0;
          valid_d = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end
      SEND: begin
        if (handshake_s && !last_s) begin
          cnt_d = cnt_q + {{(CHANNEL_WIDTH-1){1'b0}}, 1'b1};
        end else if (handshake_s && accept_s) begin
          cnt_d = '0;
        end else if (handshake_s) begin
          state_d = IDLE;
          cnt_d   = '0;
          valid_d = 1'b0;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      mismatch_q <= 1'b0;
      for (int i = 0; i < NUM_FILTERS; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      mismatch_q <= mismatch_d;
      if (accept_s) begin
        for (int i = 0; i < NUM_FILTERS; i++) begin
          buf_q[i] <= bus.serialiser_data_in[i];
        end
      end
    end
  end

  assign bus.serialiser_ready_in       = ready_in_s;
  assign bus.serialiser_valid_out      = valid_q;
  assign bus.serialiser_data_out       = data_out_s;
  assign bus.serialiser_channel_out    = cnt_q;
  assign bus.serialiser_last_out       = valid_q & last_s;
  assign bus.serialiser_valid_mismatch = mismatch_q;

endmodule

// File: doc/conv1d_layer_serialiser.md
Name: conv1d_layer_serialiser

Overview:
- Downstream consumer of the conv1d layer's parallel output interface.
  - Receives one NUM_FILTERS-wide vector of filter results, qualified by a per-filter valid vector.
  - Drives the layer's single ready_out back-pressure input.
- Replays the captured vector as a single-lane ready/valid stream: channel 0 first, channel NUM_FILTERS-1 last, with channel index and last flag.
- Optional ReLU is applied on the output side; a sticky error flag catches partially valid vectors.
- Feeds the next layer, which consumes one sample per handshake.

Parameters:
- DATA_WIDTH, 32, width of each fixed-point sample (two's complement).
- NUM_FILTERS, 32, number of parallel lanes captured per vector.
- APPLY_RELU, 0, 1 = negative samples are output as zero; 0 = pass-through.
- CHANNEL_WIDTH, max(1, clog2(NUM_FILTERS)), localparam, width of the channel index.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- serialiser_ready_in  output  1  can accept a vector; connects to the layer's ready_out.
- serialiser_valid_in  input  NUM_FILTERS  per-filter valids from the layer.
- serialiser_data_in  input  DATA_WIDTH x [0:NUM_FILTERS-1]  unpacked array of filter results.
- serialiser_ready_out  input  1  downstream ready.
- serialiser_valid_out  output  1  output sample valid.
- serialiser_data_out  output  DATA_WIDTH  output sample.
- serialiser_channel_out  output  CHANNEL_WIDTH  filter index of the current sample.
- serialiser_last_out  output  1  high with the sample for channel NUM_FILTERS-1.
- serialiser_valid_mismatch  output  1  sticky: a partial valid vector was seen.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, channel counter=0, capture buffer=0.
  - valid_out=0, data_out=0, channel_out=0, last_out=0, valid_mismatch=0.
  - ready_in=1 from the first cycle after release.
- Accept condition: accept = ready_in && (&valid_in).
- ready_in (combinational):
  - 1 in IDLE.
  - In SEND: 1 only when last_out && valid_out && ready_out, so the next vector can be captured in the same cycle the last beat leaves.
- State machine:
  - IDLE: on accept, capture all NUM_FILTERS lanes, counter=0, go to SEND.
  - SEND: valid_out=1, data_out=buffer[counter], channel_out=counter, last_out=(counter==NUM_FILTERS-1).
    - On a handshake with counter<NUM_FILTERS-1: counter+1.
    - On a handshake with counter==NUM_FILTERS-1: if accept in the same cycle, recapture, counter=0, stay in SEND; otherwise go to IDLE.
- Latency: the accept edge puts channel 0 on the output in the next cycle.
- Throughput: NUM_FILTERS beats per vector, with no bubble between back-to-back vectors.
- Back-pressure: with ready_out=0, data_out, channel_out, last_out and valid_out hold stable; the counter does not advance.
- Output register: data_out, channel_out and last_out are driven combinationally from the buffer and counter; the buffer only changes on accept.
- ReLU (APPLY_RELU=1): data_out = buffer[counter][DATA_WIDTH-1] ? 0 : buffer[counter]. No truncation or width change.
- Partial valid: valid_in nonzero but not all ones, while ready_in=1.
  - The vector is not accepted.
  - valid_mismatch sets and stays set until reset.
  - A later all-ones vector is accepted normally.
- valid_in is ignored while ready_in=0; the mismatch check applies only while ready_in=1.
- NUM_FILTERS=1: every beat has last_out=1 and channel_out=0.
- Reset mid-SEND: the output drops immediately (asynchronous), the buffer contents are discarded, and the block returns to IDLE.

Test Plan:
- NUM_FILTERS=4, DATA_WIDTH=8, lanes {0x11,0x22,0x33,0x44}, ready_out=1 -> 4 beats on consecutive cycles, channel 0..3, last_out only on 0x44; ready_in low during the first 3 beats.
- Same vector with ready_out toggling 1,0,1,0 -> every sample held stable while ready_out=0; total 4 handshakes in 8 cycles, order unchanged.
- Two vectors presented back-to-back, valid_in held at 4'b1111 -> second vector captured on the last beat of the first; 8 contiguous output beats with no gap.
- APPLY_RELU=1, lanes {0x80,0x7F,0xFF,0x01} -> outputs 0x00,0x7F,0x00,0x01.
- valid_in=4'b0101 in IDLE -> no capture, valid_out stays 0, valid_mismatch=1; then 4'b1111 -> normal 4-beat output, valid_mismatch remains 1.
- rst asserted after 2 of 4 beats -> valid_out=0 asynchronously; after release, ready_in=1 and a new vector streams from channel 0.
